alu_frame_sequencer: RTL and testbench
======================================

// Module: alu_frame_sequencer
// PURPOSE
//  Sequences the processing (ALU) port of memory_controller over one frame region.
//  Streams source pixels out to an external processing kernel and writes kernel results back to the frame buffer.
//  Sits in top between memory_controller and the kernel. Owns raddr_alu, waddr_alu, wdata_alu and wen_alu.
//  Credit-limits the kernel so results never overflow the local result FIFO.
// PARAMETERS
//  RADDR_W    13    ALU read address width
//  WADDR_W    19    ALU write address width
//  DATA_W     12    pixel width (RGB444)
//  NUM_PIX    4800  pixels per job (80x60). Must be >=1 and <=2**RADDR_W.
//  RD_BASE    0     first source read address
//  WR_BASE    0     first destination write address
//  RD_LAT     2     memory_controller read latency, cycles from raddr_alu to rdata_alu
//  FIFO_DEPTH 8     result FIFO depth, power of 2; also the in-flight credit limit
// PORTS
//  CLK100MHZ  in   1        system clock; everything in this block is synchronous to it
//  rst        in   1        synchronous, active-high reset
//  start      in   1        job request pulse; honoured only in IDLE
//  abort      in   1        cancel the current job; honoured in RUN and DRAIN
//  alu_gnt    in   1        memory_controller grants the ALU port this cycle
//  raddr_alu  out  RADDR_W  source read address
//  rdata_alu  in   DATA_W   source read data, valid RD_LAT cycles after the address
//  waddr_alu  out  WADDR_W  destination write address
//  wdata_alu  out  DATA_W   destination write data
//  wen_alu    out  1        write strobe; only ever asserted while alu_gnt=1
//  px_valid   out  1        source pixel valid to the kernel
//  px_data    out  DATA_W   source pixel to the kernel
//  res_valid  in   1        kernel result valid; results return in order
//  res_data   in   DATA_W   kernel result
//  kern_flush out  1        1-cycle pulse to clear kernel pipeline state
//  busy       out  1        high in RUN and DRAIN
//  done       out  1        1-cycle pulse when the job completes
//  ovf_err    out  1        sticky: res_valid seen while the FIFO was full or the block was not active
// BEHAVIOUR
//  Reset: state=IDLE, all counters and the FIFO cleared. All outputs 0, except raddr_alu=RD_BASE and waddr_alu=WR_BASE.
//  FSM IDLE -> RUN on start: pulse kern_flush, clear rd_cnt, wr_cnt and inflight.
//  FSM RUN: issue a read when alu_gnt && rd_cnt<NUM_PIX && inflight<FIFO_DEPTH.
//    On issue: raddr_alu=RD_BASE+rd_cnt, then rd_cnt++ and inflight++.
//  RUN -> DRAIN when rd_cnt reaches NUM_PIX.
//  DRAIN -> IDLE when wr_cnt reaches NUM_PIX; done pulses in that same transition cycle.
//  Abort (RUN/DRAIN) -> IDLE next cycle: FIFO flushed, kern_flush pulses, done is NOT pulsed.
//  Read pipeline: a RD_LAT-deep valid shift register. px_valid=1 with px_data=rdata_alu exactly RD_LAT cycles after issue.
//  Results: res_valid pushes res_data into the FIFO, only in RUN or DRAIN.
//  Writeback: when alu_gnt && FIFO non-empty, pop the FIFO, wen_alu=1, waddr_alu=WR_BASE+wr_cnt, then wr_cnt++ and inflight--.
//    waddr_alu is registered with wen_alu. Address arithmetic wraps modulo 2**WADDR_W.
//  Same-cycle issue and writeback: inflight stays unchanged. Same-cycle FIFO push and pop is legal, including when full.
//  Credit rule: inflight counts issued reads not yet written back, so inflight<=FIFO_DEPTH always.
//  res_valid with a full FIFO, or outside RUN/DRAIN: the result is dropped and ovf_err is set. ovf_err clears only on rst.
//  start while busy is ignored. start and abort together in IDLE: start wins.
//  rst mid-job: immediate return to IDLE. No write is issued in the reset cycle.
//  alu_gnt low: no issue and no write that cycle. Counters hold and the pipeline keeps advancing.
// STRUCTURE
//  Shared package alu_seq_pkg: state encoding (IDLE, RUN, DRAIN); DATA_W/RADDR_W/WADDR_W defaults;
//    NUM_PIX_QVGA_TILE=4800 constant.
//  One sub-module, seq_result_fifo: sync FIFO, DATA_W x FIFO_DEPTH.
//    Ports: push, pop, din, dout, full, empty, flush. Registered dout, first-word fall-through.
//  The FSM, counters, read-valid shift register and credit counter live in the top level of this block.
// TESTING
//  1. Kernel is identity with 3-cycle latency; alu_gnt=1; NUM_PIX=16; RD_BASE=0; WR_BASE=100; memory holds addr*3.
//     -> writes to 100..115 with data 0..45; done pulses once; busy falls on the same cycle.
//  2. Kernel latency 20 cycles, FIFO_DEPTH=8.
//     -> inflight never exceeds 8; reads stall at 8 in flight; all 16 writes still occur, in order.
//  3. alu_gnt toggles 1,0,1,0.
//     -> no raddr issue and no wen_alu in gnt=0 cycles; final memory matches test 1.
//  4. abort after 5 writes.
//     -> IDLE next cycle; kern_flush pulses; no done; no further wen_alu.
//     -> A new start then completes a full job.
//  5. Inject res_valid in IDLE, and again with the FIFO full (kernel forced to burst).
//     -> result dropped, ovf_err=1 and held until rst.
//  6. rst asserted mid-RUN, start pulsed while busy, WR_BASE=2**19-4 with NUM_PIX=8.
//     -> clean reset to IDLE; start while busy ignored; write addresses wrap to 0..3.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU frame sequencer.
//   - default widths for the ALU port of memory_controller
//   - default job size (one 80x60 tile)
//   - sequencer state encoding
package alu_seq_pkg;

    localparam int unsigned DATA_W_DEF        = 12;    // RGB444 pixel
    localparam int unsigned RADDR_W_DEF       = 13;    // ALU read address width
    localparam int unsigned WADDR_W_DEF       = 19;    // ALU write address width
    localparam int unsigned NUM_PIX_QVGA_TILE = 4800;  // 80x60 pixels per job

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_result_fifo.sv
// Synchronous result FIFO, DATA_W x FIFO_DEPTH, first-word fall-through.
// dout always shows the head entry straight out of the storage registers.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   flush       drop all contents (wins over push/pop in the same cycle)
//   push, din   write din when not full, or when full and popping
//   pop         remove the head entry (ignored when empty)
//   dout        head entry, valid while empty=0
//   full, empty status flags
module seq_result_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/alu_frame_sequencer.sv
// Sequences the ALU port of memory_controller over one frame region: streams source
// pixels to an external kernel and writes kernel results back to the frame buffer.
// Reads are credit-limited so the kernel can never overflow the local result FIFO.
// Ports:
//   CLK100MHZ, rst         clock, synchronous active-high reset
//   start, abort           job request (IDLE only) / cancel (RUN, DRAIN)
//   alu_gnt                ALU port granted this cycle
//   raddr_alu, rdata_alu   source read address / data (RD_LAT cycles later)
//   waddr_alu, wdata_alu,
//   wen_alu                destination write port
//   px_valid, px_data      source pixel stream to the kernel
//   res_valid, res_data    in-order kernel results
//   kern_flush             1-cycle pulse clearing kernel pipeline state
//   busy, done             job active / 1-cycle completion pulse
//   ovf_err                sticky: a result had to be dropped
module alu_frame_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned RADDR_W    = RADDR_W_DEF,
    parameter int unsigned WADDR_W    = WADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned NUM_PIX    = NUM_PIX_QVGA_TILE,
    parameter int unsigned RD_BASE    = 0,
    parameter int unsigned WR_BASE    = 0,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               CLK100MHZ,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               alu_gnt,
    output logic [RADDR_W-1:0] raddr_alu,
    input  logic [DATA_W-1:0]  rdata_alu,
    output logic [WADDR_W-1:0] waddr_alu,
    output logic [DATA_W-1:0]  wdata_alu,
    output logic               wen_alu,
    output logic               px_valid,
    output logic [DATA_W-1:0]  px_data,
    input  logic               res_valid,
    input  logic [DATA_W-1:0]  res_data,
    output logic               kern_flush,
    output logic               busy,
    output logic               done,
    output logic               ovf_err
);

    localparam int unsigned CntW = $clog2(NUM_PIX + 1);
    localparam int unsigned InfW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] NumPix = CntW'(NUM_PIX);
    localparam logic [InfW-1:0] Credits = InfW'(FIFO_DEPTH);

    seq_state_e         state_q, state_d;
    logic [CntW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [CntW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [InfW-1:0]    inflight_q, inflight_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [RD_LAT-1:0]  vld_q, vld_d;
    logic               kern_flush_q, kern_flush_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               active;
    logic               issue;
    logic               wr_en;
    logic               fifo_flush;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_dout;

    assign active = (state_q != StIdle);

    // Results arriving while kern_flush is high belong to the job just cancelled or
    // the pipeline state just cleared, so they are discarded without an error.
    assign fifo_push = res_valid && active && !kern_flush_q && (!fifo_full || wen_alu);

    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        inflight_d   = inflight_q;
        waddr_d      = waddr_q;
        kern_flush_d = 1'b0;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        issue        = 1'b0;
        wr_en        = 1'b0;
        fifo_flush   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StRun;
                    kern_flush_d = 1'b1;
                    fifo_flush   = 1'b1;
                    rd_cnt_d     = '0;
                    wr_cnt_d     = '0;
                    inflight_d   = '0;
                    waddr_d      = WADDR_W'(WR_BASE);
                end
            end
            StRun, StDrain: begin
                if (abort) begin
                    state_d      = StIdle;
                    kern_flush_d = 1'b1;
                    fifo_flush   = 1'b1;
                end else begin
                    issue = (state_q == StRun) && alu_gnt && (rd_cnt_q < NumPix) &&
                            (inflight_q < Credits);
                    wr_en = alu_gnt && !fifo_empty;

                    if (issue) rd_cnt_d = rd_cnt_q + CntW'(1);
                    if (wr_en) begin
                        wr_cnt_d = wr_cnt_q + CntW'(1);
                        waddr_d  = waddr_q + WADDR_W'(1);
                    end

                    // Issue and writeback in the same cycle leave the credit count alone.
                    if (issue && !wr_en) begin
                        inflight_d = inflight_q + InfW'(1);
                    end else if (!issue && wr_en && (inflight_q != '0)) begin
                        inflight_d = inflight_q - InfW'(1);
                    end

                    if (wr_cnt_d == NumPix) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if ((state_q == StRun) && (rd_cnt_d == NumPix)) begin
                        state_d = StDrain;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Read-valid pipeline tracks issued reads until their data returns.
        vld_d = (vld_q << 1) | RD_LAT'(issue);
        if (active && abort) vld_d = '0;

        if (res_valid && !fifo_push && !kern_flush_q && !(active && abort)) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
            inflight_q   <= '0;
            waddr_q      <= WADDR_W'(WR_BASE);
            vld_q        <= '0;
            kern_flush_q <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
            inflight_q   <= inflight_d;
            waddr_q      <= waddr_d;
            vld_q        <= vld_d;
            kern_flush_q <= kern_flush_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    seq_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (CLK100MHZ),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (wen_alu),
        .din   (res_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // No write may leave the block in a reset cycle.
    assign wen_alu    = wr_en && !rst;
    assign waddr_alu  = waddr_q;
    assign wdata_alu  = wen_alu ? fifo_dout : '0;
    assign raddr_alu  = RADDR_W'(RD_BASE) + RADDR_W'(rd_cnt_q);
    assign px_valid   = vld_q[RD_LAT-1];
    assign px_data    = px_valid ? rdata_alu : '0;
    assign kern_flush = kern_flush_q;
    assign busy       = active;
    assign done       = done_q;
    assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_alu_frame_sequencer.sv
// Self-checking bench: memory returns addr*3 after 2 cycles, the kernel is an identity
// pipeline of programmable latency, and expected writes are queued at job start and
// compared as wen_alu strobes appear.
module tb_alu_frame_sequencer;

    localparam int unsigned RADDR_W    = 13;
    localparam int unsigned WADDR_W    = 19;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned NUM_PIX    = 16;
    localparam int unsigned RD_BASE    = 5;
    localparam int unsigned WR_BASE    = 524284;  // 2**19-4, writes wrap to 0
    localparam int unsigned FIFO_DEPTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic               alu_gnt;
    logic [RADDR_W-1:0] raddr_alu;
    logic [DATA_W-1:0]  rdata_alu;
    logic [WADDR_W-1:0] waddr_alu;
    logic [DATA_W-1:0]  wdata_alu;
    logic               wen_alu;
    logic               px_valid;
    logic [DATA_W-1:0]  px_data;
    logic               res_valid;
    logic [DATA_W-1:0]  res_data;
    logic               kern_flush;
    logic               busy;
    logic               done;
    logic               ovf_err;

    alu_frame_sequencer #(
        .RADDR_W    (RADDR_W),
        .WADDR_W    (WADDR_W),
        .DATA_W     (DATA_W),
        .NUM_PIX    (NUM_PIX),
        .RD_BASE    (RD_BASE),
        .WR_BASE    (WR_BASE),
        .RD_LAT     (2),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK100MHZ  (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .alu_gnt    (alu_gnt),
        .raddr_alu  (raddr_alu),
        .rdata_alu  (rdata_alu),
        .waddr_alu  (waddr_alu),
        .wdata_alu  (wdata_alu),
        .wen_alu    (wen_alu),
        .px_valid   (px_valid),
        .px_data    (px_data),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .kern_flush (kern_flush),
        .busy       (busy),
        .done       (done),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 2-cycle read latency, content = address * 3.
    logic [RADDR_W-1:0] rp0, rp1;
    always @(posedge clk) begin
        rp0 <= raddr_alu;
        rp1 <= rp0;
    end
    assign rdata_alu = DATA_W'(int'(rp1) * 3);

    // Kernel model: identity with kern_lat cycles latency, plus a result injector.
    int              kern_lat;
    logic            inj;
    logic [DATA_W-1:0] inj_data;
    logic              kv [0:31];
    logic [DATA_W-1:0] kd [0:31];
    always @(posedge clk) begin
        for (int i = 0; i < 31; i++) begin
            kv[i] <= kv[i+1];
            kd[i] <= kd[i+1];
        end
        kv[31] <= 1'b0;
        kd[31] <= '0;
        if (rst || kern_flush) begin
            for (int i = 0; i < 32; i++) kv[i] <= 1'b0;
        end else if (px_valid) begin
            kv[kern_lat-1] <= 1'b1;
            kd[kern_lat-1] <= px_data;
        end
    end
    assign res_valid = kv[0] | inj;
    assign res_data  = inj ? inj_data : kd[0];

    typedef struct {
        logic [WADDR_W-1:0] a;
        logic [DATA_W-1:0]  d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        int lat;
        int gmode;        // 0: gnt=1, 1: toggle each cycle, 2: driven by hand
        int abort_after;  // -1: no abort
        int start_mid;
        int exp_wr;
        int exp_done;
        int exp_maxo;     // 0: no exact requirement
    } job_t;

    int errors;
    int checks;
    int gmode;
    int nwr, ndone, npx, maxo;
    logic g1, g2;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push_exp(input int n);
        wr_t e;
        for (int i = 0; i < n; i++) begin
            e.a = WADDR_W'((WR_BASE + i) % (1 << WADDR_W));
            e.d = DATA_W'((RD_BASE + i) * 3);
            exp_q.push_back(e);
        end
    endtask

    // Checks one cycle's outputs; called at the falling edge.
    task automatic monitor();
        wr_t e;
        if (rst) chk("rst_no_wen", wen_alu, 0);
        if (wen_alu) begin
            chk("wen_gnt", alu_gnt, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_addr", waddr_alu, -1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", waddr_alu, e.a);
                chk("wr_data", wdata_alu, e.d);
            end
            nwr++;
        end
        if (done) begin
            ndone++;
            chk("done_busy_low", busy, 0);
        end
        if (px_valid) begin
            chk("issue_gnt", g2, 1);
            npx++;
        end
        if (npx - nwr > maxo) maxo = npx - nwr;
        g2 = g1;
        g1 = alu_gnt;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (gmode == 0) alu_gnt = 1'b1;
        else if (gmode == 1) alu_gnt = ~alu_gnt;
    endtask

    task automatic run_job(input job_t v);
        int  nexp;
        bit  fin;
        nwr = 0; ndone = 0; npx = 0; maxo = 0; fin = 0;
        kern_lat = v.lat;
        gmode    = v.gmode;
        alu_gnt  = 1'b1;
        nexp = (v.abort_after < 0) ? NUM_PIX : v.abort_after;
        push_exp(nexp);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int t = 0; t < 600 && !fin; t++) begin
            start = (v.start_mid != 0) && (t == 10);
            if (v.abort_after >= 0 && nwr >= v.abort_after) begin
                abort = 1'b1;
                cycle();
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_kern_flush", kern_flush, 1);
                chk("abort_done", done, 0);
                fin = 1;
            end else begin
                cycle();
                if (ndone > 0) fin = 1;
            end
        end
        start = 1'b0;
        if (!fin) fail("job_timeout");
        repeat (40) cycle();
        chk("job_writes", nwr, v.exp_wr);
        chk("job_done_pulses", ndone, v.exp_done);
        chk("inflight_over_limit", maxo > FIFO_DEPTH, 0);
        if (v.exp_maxo > 0) chk("inflight_peak", maxo, v.exp_maxo);
        chk("job_end_busy", busy, 0);
        chk("job_exp_left", exp_q.size(), 0);
        chk("job_ovf", ovf_err, 0);
        exp_q.delete();
    endtask

    job_t vecs[6];

    initial begin
        int nwr_at_rst;
        bit fin;

        vecs[0] = '{lat: 3,  gmode: 0, abort_after: -1, start_mid: 0, exp_wr: 16,
                    exp_done: 1, exp_maxo: 0};
        vecs[1] = '{lat: 20, gmode: 0, abort_after: -1, start_mid: 0, exp_wr: 16,
                    exp_done: 1, exp_maxo: 8};
        vecs[2] = '{lat: 3,  gmode: 1, abort_after: -1, start_mid: 0, exp_wr: 16,
                    exp_done: 1, exp_maxo: 0};
        vecs[3] = '{lat: 3,  gmode: 0, abort_after: 5,  start_mid: 0, exp_wr: 5,
                    exp_done: 0, exp_maxo: 0};
        vecs[4] = '{lat: 3,  gmode: 0, abort_after: -1, start_mid: 0, exp_wr: 16,
                    exp_done: 1, exp_maxo: 0};
        vecs[5] = '{lat: 6,  gmode: 0, abort_after: -1, start_mid: 1, exp_wr: 16,
                    exp_done: 1, exp_maxo: 0};

        errors = 0; checks = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; alu_gnt = 1'b0;
        inj = 1'b0; inj_data = '0; kern_lat = 3; gmode = 2;
        g1 = 1'b0; g2 = 1'b0;
        nwr = 0; ndone = 0; npx = 0; maxo = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_raddr", raddr_alu, RD_BASE);
        chk("rst_waddr", waddr_alu, WR_BASE);
        chk("rst_wen", wen_alu, 0);
        chk("rst_wdata", wdata_alu, 0);
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_kern_flush", kern_flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf_err, 0);

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // FIFO full: kernel bursts 8 results while the port is not granted.
        nwr = 0; ndone = 0; npx = 0; maxo = 0;
        kern_lat = 20; gmode = 2; alu_gnt = 1'b1;
        push_exp(NUM_PIX);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (12) cycle();
        alu_gnt = 1'b0;
        repeat (30) cycle();
        chk("stall_px_count", npx, FIFO_DEPTH);
        chk("stall_writes", nwr, 0);
        chk("ovf_before_full_inject", ovf_err, 0);
        inj_data = 12'hABC;
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        cycle();
        chk("ovf_full_inject", ovf_err, 1);
        gmode = 0; alu_gnt = 1'b1;
        fin = 0;
        for (int t = 0; t < 600 && !fin; t++) begin
            cycle();
            if (ndone > 0) fin = 1;
        end
        if (!fin) fail("full_timeout");
        repeat (10) cycle();
        chk("full_writes", nwr, NUM_PIX);
        chk("full_done", ndone, 1);
        chk("full_exp_left", exp_q.size(), 0);
        chk("ovf_held_after_job", ovf_err, 1);
        exp_q.delete();

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("ovf_cleared_by_rst", ovf_err, 0);

        // Result while IDLE.
        inj_data = 12'h123;
        inj = 1'b1;
        cycle();
        inj = 1'b0;
        cycle();
        chk("ovf_idle_inject", ovf_err, 1);
        repeat (20) cycle();
        chk("ovf_sticky", ovf_err, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("ovf_rst_again", ovf_err, 0);

        // Reset in the middle of a job.
        nwr = 0; ndone = 0; npx = 0; maxo = 0;
        kern_lat = 3; gmode = 0; alu_gnt = 1'b1;
        push_exp(NUM_PIX);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (10) cycle();
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        nwr_at_rst = nwr;
        chk("midrst_busy", busy, 0);
        chk("midrst_raddr", raddr_alu, RD_BASE);
        chk("midrst_waddr", waddr_alu, WR_BASE);
        chk("midrst_px_valid", px_valid, 0);
        repeat (30) cycle();
        chk("midrst_no_writes", nwr, nwr_at_rst);
        chk("midrst_no_done", ndone, 0);
        chk("midrst_ovf", ovf_err, 0);

        run_job(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
